// File: rtl/xbar_slave_arbiter.sv
// Per-slave round-robin arbiter: picks one requesting master, holds the grant
// for a whole session until the slave mux reports completion, with a watchdog.
module xbar_slave_arbiter #(
  parameter int QTY_OF_DEVICES = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16,
  localparam int IDW           = $clog2(QTY_OF_DEVICES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [QTY_OF_DEVICES-1:0] req_vec,
  input  logic                      session_is_finished,
  input  logic                      err_clr,
  output logic [QTY_OF_DEVICES-1:0] granted_master,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam logic [IDW:0]   QTY_W    = (IDW+1)'(QTY_OF_DEVICES);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(QTY_OF_DEVICES - 1);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                    state_reg;
  logic [QTY_OF_DEVICES-1:0] grant_reg;
  logic [IDW-1:0]            grant_id_reg;
  logic [IDW-1:0]            ptr_reg;
  logic                      busy_reg;
  logic                      timeout_err_reg;
  logic [CNT_WIDTH-1:0]      counter_reg;

  logic [IDW-1:0]            cand_idx [QTY_OF_DEVICES];
  logic [QTY_OF_DEVICES-1:0] cand_hit;
  logic [IDW-1:0]            winner;
  logic [QTY_OF_DEVICES-1:0] win_onehot;
  logic [IDW-1:0]            next_ptr;
  logic                      wd_hit;

  // Candidate gi is the master gi positions after the pointer, wrapped.
  for (genvar gi = 0; gi < QTY_OF_DEVICES; gi++) begin : g_cand
    logic [IDW:0] sum;
    assign sum           = {1'b0, ptr_reg} + (IDW+1)'(gi);
    assign cand_idx[gi]  = (sum >= QTY_W) ? IDW'(sum - QTY_W) : sum[IDW-1:0];
    assign cand_hit[gi]  = req_vec[cand_idx[gi]];
    assign win_onehot[gi] = (winner == IDW'(gi));
  end

  // Scan from the farthest candidate so the one nearest the pointer wins.
  always_comb begin
    winner = ptr_reg;
    for (int off = QTY_OF_DEVICES - 1; off >= 0; off--) begin
      if (cand_hit[off]) winner = cand_idx[off];
    end
  end

  assign next_ptr = (grant_id_reg == LAST_IDX) ? '0 : grant_id_reg + 1'b1;

  if (TIMEOUT_CYCLES != 0) begin : g_wd
    assign wd_hit = (counter_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_wd
    assign wd_hit = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      grant_id_reg    <= '0;
      ptr_reg         <= '0;
      busy_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      counter_reg     <= '0;
    end else begin
      if (state_reg == GRANTED && wd_hit && !session_is_finished) begin
        timeout_err_reg <= 1'b1;
      end else if (err_clr) begin
        timeout_err_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            grant_reg    <= win_onehot;
            grant_id_reg <= winner;
            busy_reg     <= 1'b1;
            counter_reg  <= '0;
            state_reg    <= GRANTED;
          end
        end
        GRANTED: begin
          if (counter_reg != '1) counter_reg <= counter_reg + 1'b1;
          // The grant is never revoked by the watchdog, only by finish.
          if (session_is_finished) begin
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            ptr_reg   <= next_ptr;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign granted_master = grant_reg & ~{QTY_OF_DEVICES{session_is_finished}};
  assign grant_id       = grant_id_reg;
  assign busy           = busy_reg;
  assign timeout_err    = timeout_err_reg;

endmodule
